kp_row_scanner: RTL and testbench
=================================

# kp_row_scanner

Keypad scan driver for the Pong console's 4x4 matrix keypad. The block drives the active-low row lines, samples the active-low `kp_col` return lines, debounces the full key map once per scan frame, and produces held paddle controls (`up1`, `down1`, `up2`, `down2`) plus a one-cycle key-press event. It sits between the board keypad pins and the game FSM / paddle state machine, and owns the row-drive side of the keypad interface.

## Interface
- `SCAN_DIV`, default 250: clock cycles per row slot; legal range ≥ 4.
- `DEBOUNCE_CNT`, default 4: consecutive identical frames required to accept a new key map; legal range 1..15.
- `REPEAT_FRAMES`, default 50: auto-repeat period in frames; used only with `KP_AUTOREPEAT_EN`; legal range ≥ 1.
- `clk`  in  1  single system clock; every register is in this domain.
- `rst`  in  1  reset, synchronous and active-high.
- `kp_col`  in  4  column returns, active-low (pulled up; 0 = key closed on the driven row).
- `kp_row`  out  4  row drive, active-low one-hot; 4'b1111 means no row is driven.
- `up1`, `down1`, `up2`, `down2`  out  1 each  debounced held-key levels.
- `key_valid`  out  1  one-cycle press event.
- `key_code`  out  4  key index, row*4+col; valid when `key_valid` = 1, otherwise holds its last value.

## Operation
- `kp_col` passes through a 2-flop synchronizer before any use.
- FSM states:
  - DRIVE: `kp_row` = ~(1<<row). The slot counter runs 0..SCAN_DIV-2.
  - SAMPLE: one cycle, the last cycle of the slot, still driving the row. Latch ~synced `kp_col` into `raw[row*4 +: 4]`. If row < 3: row++ and go to DRIVE. Otherwise go to EVAL.
  - EVAL: one cycle with `kp_row` = 4'b1111. Run debounce, then row = 0 and go to DRIVE.
- Frame length is 4*SCAN_DIV + 1 cycles.
- Debounce, performed in EVAL:
  - If `raw` == `prev`: `cnt` = min(`cnt`+1, DEBOUNCE_CNT). Otherwise `cnt` = 1.
  - Always `prev` ← `raw`.
  - If the new `cnt` == DEBOUNCE_CNT: `deb` ← `raw`, and `newpress` = `raw` & ~`deb`(old).
- Key map:
  - `up1` = `deb`[0], `down1` = `deb`[4], `up2` = `deb`[3], `down2` = `deb`[7].
  - Index 15 is the start key, reported only through `key_code`.
- Press event: if `newpress` ≠ 0, `key_valid` = 1 for exactly one cycle and `key_code` = lowest set index of `newpress`.
- Several keys accepted in the same frame: only the lowest index is reported; the others produce no event.
- Releases produce no event.
- `cnt` saturates at DEBOUNCE_CNT. A stable map re-writes `deb` with the same value, so `newpress` = 0 and no event fires.

## Timing
- Reset values:
  - `kp_row` = 4'b1110 (row 0, DRIVE, slot 0).
  - `raw`, `prev`, `deb`, `cnt`, `key_valid`, `key_code`, and the synchronizer flops are all 0.
  - All level outputs are 0.
- Press latency: a key first captured in frame k (with all earlier frames clear) updates `deb` at the EVAL of frame k+DEBOUNCE_CNT-1. `key_valid` and the level outputs change on the following cycle.
- Release latency: identical, measured from the first frame in which the key is clear.
- A bounce inside a frame that changes `raw` resets `cnt` to 1 and restarts acceptance.
- Reset mid-frame: the scan restarts at row 0 and `deb` clears. A key held through reset is reported as a new press after DEBOUNCE_CNT frames.
- SAMPLE uses data that has been through the synchronizer. SCAN_DIV ≥ 4 guarantees at least 2 settle cycles plus the 2-cycle synchronizer depth.

## Configuration
- `KP_AUTOREPEAT_EN` defined:
  - Each EVAL in which `deb` is nonzero and unchanged increments a frame counter.
  - Every REPEAT_FRAMES frames it re-pulses `key_valid` with the lowest set index of `deb`.
  - The counter clears on any `deb` change, on `deb` = 0, and on reset.
- `KP_AUTOREPEAT_EN` undefined: no repeat logic and no counter. `key_valid` fires on new presses only.

## Structure
- Shared package `kp_pkg` holds:
  - the FSM state encoding (DRIVE, SAMPLE, EVAL);
  - key index constants `KEY_UP1`=0, `KEY_DOWN1`=4, `KEY_UP2`=3, `KEY_DOWN2`=7, `KEY_START`=15;
  - the row-idle constant 4'b1111.
- One sub-module, `kp_debounce`, contains the `raw`/`prev`/`cnt`/`deb` compare, the `newpress` generation and the lowest-index encoder, triggered by an `eval` strobe.
- The top-level `kp_row_scanner` contains the synchronizer, the row/slot counters and the FSM.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3, giving a 17-cycle frame.
- Reset, no keys pressed: `kp_row` cycles 1110→1101→1011→0111→1111 with period 17. `key_valid` never fires; all levels stay 0.
- Key 0 held from frame 0: at the EVAL of frame 2, `deb`[0] is set. The next cycle `up1` = 1, `key_valid` pulses one cycle, `key_code` = 0.
- Key 7 bounces (present in frame 0, absent in frame 1, present in frames 2..4): accepted only at the EVAL of frame 4; `down2` = 1 and `key_code` = 7.
- Keys 3 and 15 pressed in the same frame: one pulse, `key_code` = 3. `up2` = 1 and no second event.
- Key 4 held, `rst` asserted for one cycle mid-frame 5: `down1` = 0 the cycle after reset. It re-asserts with a fresh `key_valid` (code 4) three frames later.
- With `KP_AUTOREPEAT_EN` and REPEAT_FRAMES=2, key 0 held: after the first pulse, `key_valid` (code 0) repeats every 34 cycles until release.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared definitions for the keypad row scanner: scan FSM states, key indices,
// row-idle pattern and the lowest-set-key encoder.
package kp_pkg;

  typedef enum logic [1:0] {
    ST_DRIVE  = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2
  } kp_state_e;

  localparam int unsigned KEY_UP1   = 0;
  localparam int unsigned KEY_DOWN1 = 4;
  localparam int unsigned KEY_UP2   = 3;
  localparam int unsigned KEY_DOWN2 = 7;
  localparam int unsigned KEY_START = 15;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    lowest_idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (m[i-1]) lowest_idx = 4'(i - 1);
    end
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Frame-level key-map debouncer and press-event encoder, stepped by eval_i.
// Optional auto-repeat of the held key is enabled by defining KP_AUTOREPEAT_EN.
module kp_debounce
  import kp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT  = 4,
  parameter int unsigned REPEAT_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eval_i,
  input  logic [15:0] raw_i,
  output logic [15:0] deb_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o
);

  if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_deb
    $error("DEBOUNCE_CNT out of range 1..15");
  end
  if (REPEAT_FRAMES < 1) begin : g_bad_rep
    $error("REPEAT_FRAMES must be >= 1");
  end

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

  logic [15:0] prev_q, prev_d;
  logic [15:0] deb_q, deb_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] newpress;

`ifdef KP_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_comb begin
    prev_d   = prev_q;
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    code_d   = code_q;
    newpress = '0;
`ifdef KP_AUTOREPEAT_EN
    rep_d    = rep_q;
`endif
    if (eval_i) begin
      if (raw_i == prev_q) cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : 4'(cnt_q + 4'd1);
      else                 cnt_d = 4'd1;
      prev_d = raw_i;
      if (cnt_d == CNT_MAX) begin
        deb_d    = raw_i;
        newpress = raw_i & ~deb_q;
      end
      if (|newpress) begin
        valid_d = 1'b1;
        code_d  = lowest_idx(newpress);
      end
`ifdef KP_AUTOREPEAT_EN
      // Counts completed frames with an unchanged, nonzero accepted map.
      if (deb_d != deb_q || deb_q == '0) begin
        rep_d = '0;
      end else if (rep_q == REP_W'(REPEAT_FRAMES - 1)) begin
        rep_d   = '0;
        valid_d = 1'b1;
        code_d  = lowest_idx(deb_q);
      end else begin
        rep_d = REP_W'(rep_q + 1'b1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
`ifdef KP_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      prev_q  <= prev_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
`ifdef KP_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign deb_o       = deb_q;
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;

endmodule

// File: rtl/kp_row_scanner.sv
// 4x4 keypad scanner: column synchronizer, row/slot FSM and raw map capture,
// feeding kp_debounce. Auto-repeat is built when KP_AUTOREPEAT_EN is defined.
module kp_row_scanner
  import kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 250,
  parameter int unsigned DEBOUNCE_CNT  = 4,
  parameter int unsigned REPEAT_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_col,
  output logic [3:0] kp_row,
  output logic       up1,
  output logic       down1,
  output logic       up2,
  output logic       down2,
  output logic       key_valid,
  output logic [3:0] key_code
);

  if (SCAN_DIV < 4) begin : g_bad_div
    $error("SCAN_DIV must be >= 4");
  end

  localparam int unsigned SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 2);

  logic [3:0]        col_s1_q, col_s2_q;
  kp_state_e         state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [15:0]       raw_q, raw_d;
  logic              eval;
  logic [15:0]       deb;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    slot_d  = slot_q;
    raw_d   = raw_q;
    eval    = 1'b0;
    kp_row  = ~(4'b0001 << row_q);
    unique case (state_q)
      ST_DRIVE: begin
        if (slot_q == SLOT_LAST) begin
          slot_d  = '0;
          state_d = ST_SAMPLE;
        end else begin
          slot_d = SLOT_W'(slot_q + 1'b1);
        end
      end
      ST_SAMPLE: begin
        raw_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
        if (row_q == 2'd3) begin
          state_d = ST_EVAL;
        end else begin
          row_d   = 2'(row_q + 2'd1);
          state_d = ST_DRIVE;
        end
      end
      ST_EVAL: begin
        kp_row  = ROW_IDLE;
        eval    = 1'b1;
        row_d   = '0;
        state_d = ST_DRIVE;
      end
      default: state_d = ST_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
      state_q  <= ST_DRIVE;
      row_q    <= '0;
      slot_q   <= '0;
      raw_q    <= '0;
    end else begin
      col_s1_q <= kp_col;
      col_s2_q <= col_s1_q;
      state_q  <= state_d;
      row_q    <= row_d;
      slot_q   <= slot_d;
      raw_q    <= raw_d;
    end
  end

  kp_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .eval_i     (eval),
    .raw_i      (raw_q),
    .deb_o      (deb),
    .key_valid_o(key_valid),
    .key_code_o (key_code)
  );

  assign up1   = deb[KEY_UP1];
  assign down1 = deb[KEY_DOWN1];
  assign up2   = deb[KEY_UP2];
  assign down2 = deb[KEY_DOWN2];

endmodule

// File: tb/tb_kp_row_scanner.sv
// Frame-level randomized bench for kp_row_scanner with a key-map history model.
module tb_kp_row_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DC = 3;
  localparam int unsigned RF = 2;
  localparam int unsigned FL = 4 * SD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] kp_col;
  logic [3:0] kp_row;
  logic       up1, down1, up2, down2, key_valid;
  logic [3:0] key_code;
  logic [15:0] keys = '0;

  always #5 clk = ~clk;

  // Matrix keypad: a closed key pulls its column low while its row is driven.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kp_row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) kp_col[c] = 1'b0;
  end

  kp_row_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .kp_col   (kp_col),
    .kp_row   (kp_row),
    .up1      (up1),
    .down1    (down1),
    .up2      (up2),
    .down2    (down2),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] hist[$];
  logic [15:0] m_deb;
  logic [3:0]  m_code;
  logic        m_ev;
  int          m_hold;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] first_key(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_deb  = '0;
    m_code = '0;
    m_ev   = 1'b0;
    m_hold = 0;
  endtask

  // A map is accepted once the last DC frames since reset all read the same.
  task automatic model_eval(input logic [15:0] map);
    logic [15:0] old;
    bit stable;
    old = m_deb;
    hist.push_back(map);
    if (hist.size() > DC) void'(hist.pop_front());
    stable = (hist.size() == DC);
    foreach (hist[i]) if (hist[i] != map) stable = 0;
    if (stable) m_deb = map;
    m_ev = 1'b0;
    if ((m_deb & ~old) != 0) begin
      m_ev   = 1'b1;
      m_code = first_key(m_deb & ~old);
    end
`ifdef KP_AUTOREPEAT_EN
    if (m_deb != old || m_deb == 0) m_hold = 0;
    else begin
      m_hold++;
      if (m_hold == RF) begin
        m_hold = 0;
        m_ev   = 1'b1;
        m_code = first_key(m_deb);
      end
    end
`endif
  endtask

  // Starts #1 after the edge that begins frame cycle 0; ncyc < FL aborts the frame.
  task automatic run_frame(input logic [15:0] map, input int ncyc);
    logic [3:0] exp_row;
    logic [3:0] exp_lvl;
    keys = map;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_row = (c == FL - 1) ? 4'hF : ~(4'b0001 << (c / SD));
      exp_lvl = {m_deb[0], m_deb[4], m_deb[3], m_deb[7]};
      chk("kp_row", {12'h0, kp_row}, {12'h0, exp_row});
      chk("key_valid", {15'h0, key_valid}, {15'h0, (c == 0) ? m_ev : 1'b0});
      chk("key_code", {12'h0, key_code}, {12'h0, m_code});
      chk("levels", {12'h0, up1, down1, up2, down2}, {12'h0, exp_lvl});
      @(posedge clk);
      #1;
    end
    if (ncyc == FL) model_eval(map);
  endtask

  task automatic hold(input logic [15:0] map, input int n);
    for (int i = 0; i < n; i++) run_frame(map, FL);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] map;
    int unsigned r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    hold(16'h0000, 3);
    hold(16'h0001, 4);
    hold(16'h0000, 4);

    run_frame(16'h0080, FL);
    run_frame(16'h0000, FL);
    hold(16'h0080, 4);
    hold(16'h0000, 4);

    hold(16'h8008, 4);
    hold(16'h0000, 4);

    hold(16'h0010, 5);
    run_frame(16'h0010, 8);
    do_reset();
    hold(16'h0010, 4);
    hold(16'h0000, 4);

    map = '0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 7);
      if (r == 4 || r == 5) map = 16'h0001 << $urandom_range(0, 15);
      else if (r == 6)      map = 16'($urandom & $urandom);
      else if (r == 7)      map = '0;
      if (i == 30) begin
        run_frame(map, int'($urandom_range(1, FL - 1)));
        do_reset();
      end else begin
        run_frame(map, FL);
      end
    end
    hold(16'h0000, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
